// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS word registers, a byte FIFO
// and a serialiser. Read data is registered one cycle, like RAM.
module uart_tx_mmio #(
  parameter logic [29:0] BASE         = 30'h3FFFFFF0,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          DEPTH        = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [29:0] bus_addr,
  input  logic [31:0] bus_data_w,
  input  logic [3:0]  bus_mask_w,
  output logic [31:0] bus_data_r,
  output logic        bus_hit,
  output logic        tx
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          sel, reg_sel, rd, wr;
  logic          push, accept, pop, clr_ovf, full, busy;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bitidx;
  logic [7:0]    shreg;
  logic [31:0]   status;
  logic          unused_data_hi;

  assign sel     = (bus_addr[29:1] == BASE[29:1]);
  assign reg_sel = bus_addr[0];
  assign rd      = (bus_mask_w == 4'b0000);
  assign wr      = !rd;
  assign push    = sel && wr && !reg_sel && bus_mask_w[0];
  assign clr_ovf = sel && wr && reg_sel && bus_mask_w[0] && bus_data_w[2];
  assign full    = (count == CW'(DEPTH));
  // The serialiser takes the head either from idle or at the very end of a stop bit.
  assign pop     = (count != '0) && ((state == IDLE) || (state == STOP && baud == '0));
  assign accept  = push && (!full || pop);
  assign busy    = (state != IDLE) || (count != '0);
  assign status  = {16'd0, 8'(count), 5'd0, overflow, busy, full};
  assign unused_data_hi = ^bus_data_w[31:8];

  always_ff @(posedge clock) begin
    if (accept) mem[wr_ptr] <= bus_data_w[7:0];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A drop on the same edge as a clear leaves the flag set.
      if (push && full && !pop) overflow <= 1'b1;
      else if (clr_ovf)         overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      bus_hit    <= 1'b0;
      bus_data_r <= '0;
    end else begin
      bus_hit    <= sel && rd;
      bus_data_r <= (sel && rd && reg_sel) ? status : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      tx    <= 1'b1;
      baud  <= BAUD_RELOAD;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shreg <= mem[rd_ptr];
            tx    <= 1'b0;
            baud  <= BAUD_RELOAD;
            state <= START;
          end
        end
        START: begin
          if (baud == '0) begin
            tx     <= shreg[0];
            bitidx <= 3'd0;
            baud   <= BAUD_RELOAD;
            state  <= DATA;
          end else begin
            baud <= baud - 1'b1;
          end
        end
        DATA: begin
          if (baud == '0) begin
            baud <= BAUD_RELOAD;
            if (bitidx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shreg  <= shreg >> 1;
              tx     <= shreg[1];
              bitidx <= bitidx + 1'b1;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        STOP: begin
          if (baud == '0) begin
            baud <= BAUD_RELOAD;
            if (pop) begin
              shreg <= mem[rd_ptr];
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: a frame-level reference model predicts bus
// read data and serial frames; independent monitors decode and compare.
module tb_uart_tx_mmio;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [29:0] BASE  = 30'h100;

  logic        clock, reset;
  logic [29:0] bus_addr;
  logic [31:0] bus_data_w;
  logic [3:0]  bus_mask_w;
  logic [31:0] bus_data_r;
  logic        bus_hit;
  logic        tx;

  uart_tx_mmio #(.BASE(BASE), .CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .bus_addr(bus_addr), .bus_data_w(bus_data_w),
    .bus_mask_w(bus_mask_w), .bus_data_r(bus_data_r), .bus_hit(bus_hit), .tx(tx)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: bytes waiting, cycles left in the frame on the wire, sticky overflow.
  logic [7:0]  mq[$];
  int          rem = 0;
  bit          m_ovf = 1'b0;
  int          cyc = 0;
  int          rst_cnt = 0;
  bit          bus_act = 1'b0;
  int          et[$];
  logic [7:0]  eb[$];
  bit          eq_hit[$];
  logic [31:0] eq_data[$];

  bit          m_sel, m_rd, m_reg;
  logic [31:0] m_status;

  always @(posedge clock) begin
    cyc++;
    if (!reset) begin
      rst_cnt++;
      mq.delete(); et.delete(); eb.delete();
      rem = 0;
      m_ovf = 1'b0;
      eq_hit.push_back(1'b0);
      eq_data.push_back(32'd0);
    end else begin
      m_sel = (bus_addr[29:1] == BASE[29:1]);
      m_reg = bus_addr[0];
      m_rd  = (bus_mask_w == 4'b0000);
      m_status = {16'd0, 8'(mq.size()), 5'd0, m_ovf,
                  (rem != 0 || mq.size() != 0), (mq.size() == DEPTH)};
      if (bus_act) begin
        eq_hit.push_back(m_sel && m_rd);
        eq_data.push_back((m_sel && m_rd && m_reg) ? m_status : 32'd0);
      end
      if (mq.size() != 0 && rem <= 1) begin
        eb.push_back(mq.pop_front());
        et.push_back(cyc);
        rem = 10 * CPB;
      end else if (rem > 0) begin
        rem--;
      end
      if (!m_rd && m_sel && !m_reg && bus_mask_w[0]) begin
        if (mq.size() < DEPTH) mq.push_back(bus_data_w[7:0]);
        else m_ovf = 1'b1;
      end else if (!m_rd && m_sel && m_reg && bus_mask_w[0] && bus_data_w[2]) begin
        m_ovf = 1'b0;
      end
    end
  end

  initial begin : bus_mon
    forever begin
      @(negedge clock);
      if (eq_hit.size() != 0) begin
        chk("bus_hit", 32'(bus_hit), 32'(eq_hit.pop_front()));
        chk("bus_data_r", bus_data_r, eq_data.pop_front());
      end
    end
  end

  initial begin : frame_mon
    int t0, rc;
    logic [7:0] b;
    logic sb;
    forever begin
      @(negedge clock);
      if (tx === 1'b0) begin
        t0 = cyc;
        rc = rst_cnt;
        b  = 8'h00;
        repeat (CPB / 2) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clock);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clock);
        sb = tx;
        // A frame cut short by reset is discarded; the model already dropped it.
        if (rc == rst_cnt) begin
          if (eb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_unexpected: got byte 0x%0h at cycle %0d, expected no frame", b, t0);
          end else begin
            chk("frame_start_cycle", 32'(t0), 32'(et.pop_front()));
            chk("frame_byte", 32'(b), 32'(eb.pop_front()));
            chk("frame_stop_bit", 32'(sb), 32'd1);
          end
        end
      end
    end
  end

  task automatic bus_op(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
    bus_addr   = a;
    bus_data_w = d;
    bus_mask_w = m;
    bus_act    = 1'b1;
    @(negedge clock);
    bus_act    = 1'b0;
    bus_addr   = 30'h0;
    bus_data_w = 32'h0;
    bus_mask_w = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin : stim
    logic [29:0] a;
    logic [3:0]  m;
    reset = 1'b0;
    bus_addr = 30'h0;
    bus_data_w = 32'h0;
    bus_mask_w = 4'h0;

    // Reset and first STATUS read
    idle(3);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_hit", 32'(bus_hit), 32'd0);
    reset = 1'b1;
    bus_op(BASE | 30'h1, 32'h0, 4'h0);
    chk("first_status_hit", 32'(bus_hit), 32'd1);
    chk("first_status_data", bus_data_r, 32'd0);

    // Single byte, STATUS polled through the frame
    bus_op(BASE, 32'h55, 4'h1);
    for (int i = 0; i < 44; i++) bus_op(BASE | 30'h1, 32'h0, 4'h0);
    chk("idle_after_frame", bus_data_r, 32'd0);

    // Six back-to-back writes: one pops immediately, the sixth overflows
    for (int i = 0; i < 6; i++) bus_op(BASE, 32'($urandom_range(0, 255)), 4'h1);
    bus_op(BASE | 30'h1, 32'h0, 4'h0);
    chk("status_full_ovf", bus_data_r, 32'h0000_0407);
    bus_op(BASE | 30'h1, 32'h4, 4'h1);
    bus_op(BASE | 30'h1, 32'h0, 4'h0);
    chk("status_ovf_cleared", 32'(bus_data_r[2]), 32'd0);
    idle(5 * 10 * CPB + 10);

    // Reset mid-frame with bytes queued
    bus_op(BASE, 32'hA5, 4'h1);
    bus_op(BASE, 32'h3C, 4'h1);
    bus_op(BASE, 32'hC3, 4'h1);
    idle(7);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("midframe_reset_tx", 32'(tx), 32'd1);
    bus_op(BASE | 30'h1, 32'h0, 4'h0);
    chk("midframe_reset_status", bus_data_r, 32'd0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      chk("tx_quiet_after_reset", 32'(tx), 32'd1);
    end

    // Writes that must not push, and a non-selected read
    bus_op(BASE | 30'h2, 32'h41, 4'h1);
    bus_op(BASE, 32'h41, 4'h2);
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      chk("tx_no_push", 32'(tx), 32'd1);
    end
    bus_op(BASE - 30'h1, 32'h0, 4'h0);
    chk("nonsel_hit", 32'(bus_hit), 32'd0);
    chk("nonsel_data", bus_data_r, 32'd0);

    // Randomised traffic against the model
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: a = BASE;
        3:       a = BASE | 30'h1;
        4:       a = ($urandom_range(0, 1) != 0) ? (BASE | 30'h2) : (BASE - 30'h1);
        default: a = 30'($urandom);
      endcase
      m = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      bus_op(a, $urandom, m);
      idle($urandom_range(0, 12));
    end

    for (int i = 0; i < 4000 && (mq.size() != 0 || rem != 0); i++) @(negedge clock);
    chk("drain_done", 32'(mq.size() != 0 || rem != 0), 32'd0);
    idle(4);
    bus_op(BASE | 30'h1, 32'h0, 4'h0);
    chk("frames_outstanding", 32'(eb.size()), 32'd0);
    chk("final_not_busy", 32'(bus_data_r[1]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout at %0t, expected test completion", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
